// File: rtl/averager_accumulator.sv
// Read-modify-write bin accumulator fed by the averager counter, with snapshot readout.
// Optional build macro SATURATE_EN: saturating adds plus a sticky sat_flag output.
module averager_accumulator #(
  parameter int DATA_WIDTH   = 14,
  parameter int ACC_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clken,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         init,
  input  logic                         wen,
  output logic [ADDR_WIDTH-1:0]        bram_raddr,
  input  logic [ACC_WIDTH-1:0]         bram_rdata,
  output logic [ADDR_WIDTH-1:0]        bram_waddr,
  output logic [ACC_WIDTH-1:0]         bram_wdata,
  output logic [3:0]                   bram_we,
  output logic [ACC_WIDTH-1:0]         dout,
  output logic [ADDR_WIDTH-1:0]        dout_addr,
  output logic                         dout_valid,
  output logic                         clear_active
`ifdef SATURATE_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int RL = READ_LATENCY;

  logic clear_pending_q, clear_pending_d;
  logic clear_pass_q, clear_pass_d;
  logic addr_zero, pass_start;

  assign addr_zero  = (address == '0);
  // A frame boundary (address 0) starts a clear pass if one is armed, including by an init in the same cycle.
  assign pass_start = clken && addr_zero && (clear_pending_q || init);

  always_comb begin
    clear_pending_d = clear_pending_q;
    clear_pass_d    = clear_pass_q;
    if (pass_start) begin
      clear_pass_d    = 1'b1;
      clear_pending_d = 1'b0;
    end else if (clken) begin
      if (addr_zero) clear_pass_d = 1'b0;
      if (init) clear_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clear_pending_q <= 1'b0;
      clear_pass_q    <= 1'b0;
    end else begin
      clear_pending_q <= clear_pending_d;
      clear_pass_q    <= clear_pass_d;
    end
  end

  assign clear_active = clear_pass_q;

  logic [RL:0]                  valid_q, wen_q, clr_q;
  logic signed [DATA_WIDTH-1:0] din_q  [RL+1];
  logic [ADDR_WIDTH-1:0]        addr_q [RL+1];

  // Index 0 is the input register driving the read port; index RL lines up with bram_rdata.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      wen_q   <= '0;
      clr_q   <= '0;
      for (int k = 0; k <= RL; k++) begin
        din_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      valid_q <= {valid_q[RL-1:0], clken};
      wen_q   <= {wen_q[RL-1:0], clken & wen};
      clr_q   <= {clr_q[RL-1:0], clken & clear_pass_d};
      if (clken) begin
        din_q[0]  <= din;
        addr_q[0] <= address;
      end
      for (int k = 1; k <= RL; k++) begin
        din_q[k]  <= din_q[k-1];
        addr_q[k] <= addr_q[k-1];
      end
    end
  end

  assign bram_raddr = addr_q[0];

  logic [ACC_WIDTH-1:0] base, addend, sum_wrap, sum;

  assign base     = clr_q[RL] ? '0 : bram_rdata;
  assign addend   = {{(ACC_WIDTH-DATA_WIDTH){din_q[RL][DATA_WIDTH-1]}}, din_q[RL]};
  assign sum_wrap = base + addend;

`ifdef SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic ovf;
  logic sat_q;

  assign ovf = (base[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
               (sum_wrap[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
  assign sum = ovf ? (base[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_q <= 1'b0;
    end else if (valid_q[RL] && ovf) begin
      sat_q <= 1'b1;
    end else if (pass_start) begin
      sat_q <= 1'b0;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sum = sum_wrap;
`endif

  logic                  we_q, dout_valid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, dout_addr_q;
  logic [ACC_WIDTH-1:0]  wdata_q, dout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      dout_q       <= '0;
      dout_addr_q  <= '0;
    end else begin
      we_q         <= valid_q[RL];
      dout_valid_q <= valid_q[RL] & wen_q[RL];
      if (valid_q[RL]) begin
        waddr_q <= addr_q[RL];
        wdata_q <= sum;
      end
      if (valid_q[RL] && wen_q[RL]) begin
        dout_q      <= sum;
        dout_addr_q <= addr_q[RL];
      end
    end
  end

  assign bram_we    = {4{we_q}};
  assign bram_waddr = waddr_q;
  assign bram_wdata = wdata_q;
  assign dout       = dout_q;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_averager_accumulator.sv
// Directed vector bench for averager_accumulator with a 16-bit accumulator and an 8-bin BRAM model.
// Expectations follow SATURATE_EN when the bench is built with that macro.
module tb_averager_accumulator;

  localparam int DW  = 14;
  localparam int AW  = 16;
  localparam int ADW = 15;
  localparam int RL  = 2;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b1;
  logic                  clken = 1'b0;
  logic signed [DW-1:0]  din = '0;
  logic [ADW-1:0]        address = '0;
  logic                  init = 1'b0;
  logic                  wen = 1'b0;
  logic [ADW-1:0]        bram_raddr, bram_waddr, dout_addr;
  logic [AW-1:0]         bram_rdata, bram_wdata, dout;
  logic [3:0]            bram_we;
  logic                  dout_valid, clear_active;
`ifdef SATURATE_EN
  logic                  sat_flag;
`endif

  averager_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .clken(clken), .din(din), .address(address),
    .init(init), .wen(wen), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .clear_active(clear_active)
`ifdef SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port BRAM with two-cycle read latency; pokeEn preloads every bin.
  logic [AW-1:0] mem [8];
  logic [AW-1:0] rd1, rd2;
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeVal = '0;

  always @(posedge clk) begin
    rd1 <= mem[bram_raddr[4:2]];
    rd2 <= rd1;
    if (pokeEn) begin
      for (int i = 0; i < 8; i++) mem[i] <= pokeVal;
    end else if (bram_we == 4'hF) begin
      mem[bram_waddr[4:2]] <= bram_wdata;
    end
  end
  assign bram_rdata = rd2;

  typedef struct {
    logic                 clken;
    logic signed [DW-1:0] din;
    logic [ADW-1:0]       addr;
    logic                 init;
    logic                 wen;
    logic                 expWe;
    logic [AW-1:0]        expData;
    logic                 expDv;
    logic                 expClr;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input logic c, input int d, input int a, input logic i, input logic w,
                        input logic ew, input int ed, input logic edv, input logic ec);
    vec_t v;
    v.clken   = c;
    v.din     = DW'(d);
    v.addr    = ADW'(a);
    v.init    = i;
    v.wen     = w;
    v.expWe   = ew;
    v.expData = AW'(ed);
    v.expDv   = edv;
    v.expClr  = ec;
    vecs.push_back(v);
  endtask

  task automatic addFrame(input int d, input int initAt, input logic w, input int ed, input logic ec);
    for (int k = 0; k < 8; k++) addVec(1'b1, d, k * 4, (k == initAt), w, 1'b1, ed, w, ec);
  endtask

  task automatic checkOutput(input int i);
    vec_t v;
    v = vecs[i];
    cmp("bram_we", i, 32'(bram_we), v.expWe ? 32'hF : 32'h0);
    if (v.expWe) begin
      cmp("bram_waddr", i, 32'(bram_waddr), 32'(v.addr));
      cmp("bram_wdata", i, 32'(bram_wdata), 32'(v.expData));
    end
    cmp("dout_valid", i, 32'(dout_valid), 32'(v.expDv));
    if (v.expDv) begin
      cmp("dout", i, 32'(dout), 32'(v.expData));
      cmp("dout_addr", i, 32'(dout_addr), 32'(v.addr));
    end
  endtask

  // Vector j is driven in cycle j; its write is visible in cycle j+4 and its read address in cycle j+1.
  task automatic applyStimulus(input int first, input int last);
    for (int j = first; j <= last + 4; j++) begin
      @(posedge clk);
      #1;
      if (j <= last) begin
        clken   = vecs[j].clken;
        din     = vecs[j].din;
        address = vecs[j].addr;
        init    = vecs[j].init;
        wen     = vecs[j].wen;
      end else begin
        clken = 1'b0;
        init  = 1'b0;
        wen   = 1'b0;
      end
      @(negedge clk);
      if (j - 1 >= first && j - 1 <= last) begin
        cmp("clear_active", j - 1, 32'(clear_active), 32'(vecs[j-1].expClr));
        if (vecs[j-1].clken) cmp("bram_raddr", j - 1, 32'(bram_raddr), 32'(vecs[j-1].addr));
      end
      if (j - 4 >= first) checkOutput(j - 4);
    end
  endtask

  task automatic poke(input logic [AW-1:0] val);
    @(posedge clk);
    #1;
    pokeVal = val;
    pokeEn  = 1'b1;
    @(posedge clk);
    #1;
    pokeEn = 1'b0;
  endtask

  task automatic checkAllZero(input int tag);
    cmp("rst_raddr", tag, 32'(bram_raddr), 32'h0);
    cmp("rst_waddr", tag, 32'(bram_waddr), 32'h0);
    cmp("rst_wdata", tag, 32'(bram_wdata), 32'h0);
    cmp("rst_we", tag, 32'(bram_we), 32'h0);
    cmp("rst_dout", tag, 32'(dout), 32'h0);
    cmp("rst_dout_addr", tag, 32'(dout_addr), 32'h0);
    cmp("rst_dout_valid", tag, 32'(dout_valid), 32'h0);
    cmp("rst_clear_active", tag, 32'(clear_active), 32'h0);
  endtask

  int s1a, s1b, s2a, s2b, s3a, s3b, s4a, s4b, s5a, s5b;

  initial begin
    // Frames 0-2 of din=5 with init on the first sample, then a bubbly din=3 frame, then wen/non-wen frames.
    s1a = vecs.size();
    addFrame(5, 0, 1'b0, 5, 1'b1);
    addFrame(5, -1, 1'b0, 10, 1'b0);
    addFrame(5, -1, 1'b0, 15, 1'b0);
    for (int k = 0; k < 8; k++) begin
      addVec(1'b1, 3, k * 4, 1'b0, 1'b0, 1'b1, 18, 1'b0, 1'b0);
      addVec(1'b0, 7, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    end
    addFrame(-2, -1, 1'b1, 16, 1'b0);
    addFrame(0, -1, 1'b0, 16, 1'b0);
    s1b = vecs.size() - 1;
    // Bins preloaded with 100; init at bin 6 arms a clear for the following frame only.
    s2a = vecs.size();
    addFrame(1, 6, 1'b0, 101, 1'b0);
    addFrame(7, -1, 1'b0, 7, 1'b1);
    addFrame(1, -1, 1'b0, 8, 1'b0);
    s2b = vecs.size() - 1;
    s3a = vecs.size();
    addFrame(1, -1, 1'b0, 9, 1'b0);
    s3b = vecs.size() - 1;
    s4a = vecs.size();
`ifdef SATURATE_EN
    addFrame(100, -1, 1'b0, 32767, 1'b0);
`else
    addFrame(100, -1, 1'b0, 32860, 1'b0);
`endif
    s4b = vecs.size() - 1;
    s5a = vecs.size();
    addFrame(1, 0, 1'b0, 1, 1'b1);
    s5b = vecs.size() - 1;

    #3 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero(-1);
    resetn = 1'b1;

    poke(16'h1234);
    applyStimulus(s1a, s1b);
    poke(16'd100);
    applyStimulus(s2a, s2b);

    // Three samples in flight (the first starting a clear pass) when reset hits mid-cycle.
    @(posedge clk); #1 clken = 1'b1; din = 14'sd50; address = 15'd0; init = 1'b1; wen = 1'b0;
    @(posedge clk); #1 address = 15'd4; init = 1'b0;
    @(posedge clk); #1 address = 15'd8;
    @(posedge clk); #1 clken = 1'b0;
    #2;
    cmp("pre_rst_raddr", -2, 32'(bram_raddr), 32'd8);
    cmp("pre_rst_clear_active", -2, 32'(clear_active), 32'd1);
    resetn = 1'b0;
    #1;
    checkAllZero(-2);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmp("we_after_reset", c, 32'(bram_we), 32'h0);
    end
    applyStimulus(s3a, s3b);

    poke(16'h7FF8);
`ifdef SATURATE_EN
    cmp("sat_flag_before", -3, 32'(sat_flag), 32'd0);
`endif
    applyStimulus(s4a, s4b);
`ifdef SATURATE_EN
    cmp("sat_flag_set", -3, 32'(sat_flag), 32'd1);
`endif
    applyStimulus(s5a, s5b);
`ifdef SATURATE_EN
    cmp("sat_flag_cleared", -3, 32'(sat_flag), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
